// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, parallel load, left/right shift with serial ports and a
// saturating shift counter. Define ROTATE_EN to add the rot_i port for rotate shifts.
module univ_shift_reg #(
    parameter  int WIDTH = 4,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,     // asynchronous, active-low
    input  logic             en_i,
    input  logic [1:0]       mode_i,
    input  logic [WIDTH-1:0] pin_i,
    input  logic             sin_r_i,
    input  logic             sin_l_i,
`ifdef ROTATE_EN
    input  logic             rot_i,
`endif
    output logic [WIDTH-1:0] pout_o,
    output logic             sout_r_o,
    output logic             sout_l_o,
    output logic [CW-1:0]    cnt_o,
    output logic             full_o,
    output logic             word_vld_o
);

    localparam logic [1:0]    MODE_HOLD = 2'b00;
    localparam logic [1:0]    MODE_SHR  = 2'b01;
    localparam logic [1:0]    MODE_SHL  = 2'b10;
    localparam logic [1:0]    MODE_LOAD = 2'b11;
    localparam logic [CW-1:0] CNT_MAX   = CW'(WIDTH);

    logic             rot;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             fill_q, fill_d;
    logic             word_vld_q;

`ifdef ROTATE_EN
    assign rot = rot_i;
`else
    assign rot = 1'b0;
`endif

    always_comb begin
        data_d = data_q;
        cnt_d  = cnt_q;
        fill_d = 1'b0;
        if (en_i) begin
            case (mode_i)
                MODE_SHR: data_d = {(rot ? data_q[0] : sin_r_i), data_q[WIDTH-1:1]};
                MODE_SHL: data_d = {data_q[WIDTH-2:0], (rot ? data_q[WIDTH-1] : sin_l_i)};
                MODE_LOAD: begin
                    data_d = pin_i;
                    cnt_d  = '0;
                end
                default: ;
            endcase
            if (mode_i == MODE_SHR || mode_i == MODE_SHL) begin
                if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
                fill_d = (cnt_q == CNT_MAX - 1'b1);
            end
        end
    end

    // fill_q marks the edge that completed the word; word_vld follows one edge later
    // and is not gated by en_i, so it is always a single-cycle pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q     <= '0;
            cnt_q      <= '0;
            fill_q     <= 1'b0;
            word_vld_q <= 1'b0;
        end else begin
            data_q     <= data_d;
            cnt_q      <= cnt_d;
            fill_q     <= fill_d;
            word_vld_q <= fill_q;
        end
    end

    assign pout_o     = data_q;
    assign sout_r_o   = data_q[0];
    assign sout_l_o   = data_q[WIDTH-1];
    assign cnt_o      = cnt_q;
    assign full_o     = (cnt_q == CNT_MAX);
    assign word_vld_o = word_vld_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed-vector bench for univ_shift_reg at WIDTH=4; rotate scenario only with ROTATE_EN.
module tb_univ_shift_reg;

    localparam int WIDTH = 4;
    localparam int CW    = $clog2(WIDTH + 1);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             en = 1'b0;
    logic [1:0]       mode = 2'b00;
    logic [WIDTH-1:0] pin = '0;
    logic             sin_r = 1'b0;
    logic             sin_l = 1'b0;
    logic             rot = 1'b0;
    logic [WIDTH-1:0] pout;
    logic             sout_r, sout_l, full, word_vld;
    logic [CW-1:0]    cnt;

    int nvec = 0;
    int nerr = 0;

    univ_shift_reg #(.WIDTH(WIDTH)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .en_i       (en),
        .mode_i     (mode),
        .pin_i      (pin),
        .sin_r_i    (sin_r),
        .sin_l_i    (sin_l),
`ifdef ROTATE_EN
        .rot_i      (rot),
`endif
        .pout_o     (pout),
        .sout_r_o   (sout_r),
        .sout_l_o   (sout_l),
        .cnt_o      (cnt),
        .full_o     (full),
        .word_vld_o (word_vld)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [WIDTH-1:0] v);
        en = 1'b1; mode = 2'b11; pin = v;
        tick();
    endtask

    task automatic test_reset();
        #3;
        nvec++;
        if ({pout, cnt, full, word_vld, sout_r, sout_l} !== '0) begin
            nerr++;
            $display("FAIL reset_initial: pout=%b cnt=%0d full=%b wv=%b, want all zero", pout, cnt, full, word_vld);
        end
        @(negedge clk);
        rst_n = 1'b1;
        load(4'b0110);
        mode = 2'b10; sin_l = 1'b1;
        tick();
        tick();
        nvec++;
        if (pout !== 4'b1011 || cnt !== 3'd2) begin
            nerr++;
            $display("FAIL reset_setup: pout=%b cnt=%0d, want 1011/2", pout, cnt);
        end
        en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        nvec++;
        if ({pout, cnt, full, word_vld, sout_r, sout_l} !== '0) begin
            nerr++;
            $display("FAIL reset_async: pout=%b cnt=%0d full=%b wv=%b, want all zero", pout, cnt, full, word_vld);
        end
        #1 rst_n = 1'b1;
    endtask

    task automatic test_load_hold();
        load(4'b1010);
        nvec++;
        if (pout !== 4'b1010 || cnt !== 3'd0 || sout_r !== 1'b0 || sout_l !== 1'b1) begin
            nerr++;
            $display("FAIL load: pout=%b cnt=%0d sr=%b sl=%b, want 1010/0/0/1", pout, cnt, sout_r, sout_l);
        end
        mode = 2'b00; pin = 4'b0101;
        for (int i = 0; i < 3; i++) begin
            tick();
            nvec++;
            if (pout !== 4'b1010 || cnt !== 3'd0) begin
                nerr++;
                $display("FAIL hold%0d: pout=%b cnt=%0d, want 1010/0", i, pout, cnt);
            end
        end
    endtask

    task automatic test_sipo_right();
        logic [3:0] bits;
        logic [3:0] exp_p [4];
        bits = 4'b1101;   // applied LSB-first: 1,0,1,1
        exp_p[0] = 4'b1000; exp_p[1] = 4'b0100; exp_p[2] = 4'b1010; exp_p[3] = 4'b1101;
        load(4'b0000);
        mode = 2'b01;
        for (int i = 0; i < 4; i++) begin
            sin_r = bits[i];
            tick();
            nvec++;
            if (pout !== exp_p[i] || cnt !== CW'(i + 1) || full !== (i == 3) || word_vld !== 1'b0) begin
                nerr++;
                $display("FAIL sipo_shift%0d: pout=%b cnt=%0d full=%b wv=%b, want %b/%0d/%b/0",
                         i, pout, cnt, full, word_vld, exp_p[i], i + 1, (i == 3));
            end
        end
        sin_r = 1'b0;
        tick();
        nvec++;
        if (pout !== 4'b0110 || cnt !== 3'd4 || full !== 1'b1 || word_vld !== 1'b1) begin
            nerr++;
            $display("FAIL sipo_sat: pout=%b cnt=%0d full=%b wv=%b, want 0110/4/1/1", pout, cnt, full, word_vld);
        end
        mode = 2'b00;
        tick();
        nvec++;
        if (word_vld !== 1'b0 || cnt !== 3'd4) begin
            nerr++;
            $display("FAIL sipo_pulse_end: wv=%b cnt=%0d, want 0/4", word_vld, cnt);
        end
    endtask

    task automatic test_piso_left();
        logic [3:0] exp_sl;
        exp_sl = 4'b0011;   // index i = sout_l after i shifts: 1,1,0,0
        load(4'b1100);
        mode = 2'b10; sin_l = 1'b0;
        for (int i = 0; i < 4; i++) begin
            nvec++;
            if (sout_l !== exp_sl[i]) begin
                nerr++;
                $display("FAIL piso_bit%0d: sout_l=%b, want %b", i, sout_l, exp_sl[i]);
            end
            tick();
        end
        nvec++;
        if (pout !== 4'b0000 || cnt !== 3'd4) begin
            nerr++;
            $display("FAIL piso_end: pout=%b cnt=%0d, want 0000/4", pout, cnt);
        end
        mode = 2'b00;
        tick();
    endtask

    task automatic test_en_gating();
        logic [3:0] en_seq;
        en_seq = 4'b1001;
        load(4'b0000);
        mode = 2'b01; sin_r = 1'b1;
        for (int i = 0; i < 4; i++) begin
            en = en_seq[i];
            tick();
        end
        nvec++;
        if (cnt !== 3'd2 || pout !== 4'b1100 || full !== 1'b0) begin
            nerr++;
            $display("FAIL en_gate: pout=%b cnt=%0d full=%b, want 1100/2/0", pout, cnt, full);
        end
        en = 1'b1;
        tick();
        tick();
        en = 1'b0;
        tick();
        nvec++;
        if (word_vld !== 1'b1 || pout !== 4'b1111 || cnt !== 3'd4) begin
            nerr++;
            $display("FAIL en_pulse_rise: wv=%b pout=%b cnt=%0d, want 1/1111/4", word_vld, pout, cnt);
        end
        tick();
        nvec++;
        if (word_vld !== 1'b0) begin
            nerr++;
            $display("FAIL en_pulse_clear: wv=%b, want 0", word_vld);
        end
    endtask

    task automatic test_load_while_full();
        load(4'b0000);
        mode = 2'b10; sin_l = 1'b1;
        repeat (4) tick();
        load(4'b0101);
        nvec++;
        if (pout !== 4'b0101 || cnt !== 3'd0 || full !== 1'b0 || word_vld !== 1'b1) begin
            nerr++;
            $display("FAIL load_full: pout=%b cnt=%0d full=%b wv=%b, want 0101/0/0/1", pout, cnt, full, word_vld);
        end
        mode = 2'b00;
        tick();
        nvec++;
        if (word_vld !== 1'b0 || pout !== 4'b0101) begin
            nerr++;
            $display("FAIL load_full_after: wv=%b pout=%b, want 0/0101", word_vld, pout);
        end
    endtask

    task automatic test_reset_pending();
        load(4'b0000);
        mode = 2'b01; sin_r = 1'b1;
        repeat (4) tick();
        mode = 2'b00;
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        tick();
        nvec++;
        if (word_vld !== 1'b0 || cnt !== 3'd0 || pout !== 4'b0000) begin
            nerr++;
            $display("FAIL reset_pending: wv=%b cnt=%0d pout=%b, want 0/0/0000", word_vld, cnt, pout);
        end
    endtask

`ifdef ROTATE_EN
    task automatic test_rotate();
        logic [3:0] exp_p [4];
        exp_p[0] = 4'b0100; exp_p[1] = 4'b0010; exp_p[2] = 4'b0001; exp_p[3] = 4'b1000;
        load(4'b1000);
        mode = 2'b01; rot = 1'b1; sin_r = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            nvec++;
            if (pout !== exp_p[i] || word_vld !== 1'b0) begin
                nerr++;
                $display("FAIL rot%0d: pout=%b wv=%b, want %b/0", i, pout, word_vld, exp_p[i]);
            end
        end
        mode = 2'b00;
        tick();
        nvec++;
        if (word_vld !== 1'b1 || cnt !== 3'd4) begin
            nerr++;
            $display("FAIL rot_pulse: wv=%b cnt=%0d, want 1/4", word_vld, cnt);
        end
        tick();
        nvec++;
        if (word_vld !== 1'b0) begin
            nerr++;
            $display("FAIL rot_pulse_end: wv=%b, want 0", word_vld);
        end
        rot = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_load_hold();
        test_sipo_right();
        test_piso_left();
        test_en_gating();
        test_load_while_full();
        test_reset_pending();
`ifdef ROTATE_EN
        test_rotate();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/univ_shift_reg.md
# univ_shift_reg

Parametrised universal shift register: a WIDTH-bit register with hold, parallel load, left shift and right shift modes, serial inputs and outputs at both ends, and a shift counter that flags when a complete serial word has been assembled. It is the general-purpose data-staging register in the datapath. It covers PIPO, SIPO, PISO and SISO use from one block, and is used for serial/parallel conversion at the block edge.

## Interface
- WIDTH, 4, register width in bits; legal range 2..64.
- CW, $clog2(WIDTH+1), counter width; derived, not overridden.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-low.
- en  input  1  clock enable; when 0, the register and counter hold.
- mode  input  2  00 hold, 01 shift right, 10 shift left, 11 parallel load.
- pin  input  WIDTH  parallel data, captured in load mode.
- sin_r  input  1  serial input entering at the MSB on a right shift.
- sin_l  input  1  serial input entering at the LSB on a left shift.
- rot  input  1  rotate select; present only with ROTATE_EN.
- pout  output  WIDTH  register contents.
- sout_r  output  1  pout[0], the bit leaving on a right shift.
- sout_l  output  1  pout[WIDTH-1], the bit leaving on a left shift.
- cnt  output  CW  shifts since the last load or reset, saturating at WIDTH.
- full  output  1  high when cnt == WIDTH.
- word_vld  output  1  one-cycle pulse marking word completion.

## Operation
- Reset (rst low, asynchronous) sets pout=0, cnt=0 and word_vld=0. full=0 and sout_r=sout_l=0 follow from these.
- All updates occur on the rising edge of clk, and only when en=1, except word_vld (see Timing).
- Hold (00): no change to the register or counter.
- Load (11): pout<=pin and cnt<=0.
- Shift right (01): pout<={sin_r, pout[WIDTH-1:1]}.
- Shift left (10): pout<={pout[WIDTH-2:0], sin_l}.
- Any shift increments cnt by 1, saturating at WIDTH. Shifting continues past saturation, but cnt stays at WIDTH.
- full is combinational from cnt; no other output is combinational.
- word_vld is a register. It is set on the edge following the shift that moves cnt from WIDTH-1 to WIDTH, and it is cleared on every other edge.
- Mode changes between shift directions do not reset cnt. Only a load or a reset clears cnt.

## Timing
- Load latency: pin appears on pout one cycle after the edge.
- SIPO: WIDTH consecutive shifts fill the word. full rises in the same cycle pout holds the complete word. word_vld is high for exactly the next cycle.
- PISO: after a load, sout_r (right shift) or sout_l (left shift) presents the first bit immediately. Each further bit follows one edge later.
- word_vld clears on the next edge even if en=0, so the pulse is never stretched.
- Load issued while full=1: cnt returns to 0 and full drops the next cycle. word_vld, if currently high, drops as normal.
- Reset asserted mid-word: everything clears immediately. The partial word is discarded and no word_vld is produced.
- Reset release is synchronised externally; the block requires no setup beyond one clk edge.

## Configuration
- ROTATE_EN defined: the rot port exists. With rot=1, a right shift feeds pout[0] into the MSB and a left shift feeds pout[WIDTH-1] into the LSB; sin_r and sin_l are ignored. Rotations count in cnt exactly like shifts. With rot=0, behaviour is as in Operation.
- ROTATE_EN undefined: no rot port; shifts always use sin_r and sin_l.

## Test plan
All scenarios use WIDTH=4.
- Reset: rst low mid-run with pout=1011 and cnt=2 -> pout=0000, cnt=0, full=0 and word_vld=0 immediately, without waiting for clk.
- Load/hold: en=1, mode=11, pin=1010, then mode=00 for 3 cycles -> pout=1010 held, cnt=0.
- SIPO right: after a load of 0000, mode=01 with sin_r sequence 1,0,1,1 -> pout=1101, full=1 after the 4th edge, word_vld high for exactly one cycle after that, cnt stays at 4 on a 5th shift.
- PISO left: load 1100, then mode=10 with sin_l=0 -> sout_l sequence 1,1,0,0 on successive cycles, pout=0000 after 4 shifts.
- en gating: with mode=01, toggle en 1,0,0,1 -> exactly 2 shifts occur, cnt=2. If word_vld was pending when en dropped, it still clears after one cycle.
- ROTATE_EN: load 1000, then rot=1, mode=01 for 4 edges -> pout sequence 0100, 0010, 0001, 1000, with word_vld pulsing once.
